// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit: state encodings,
// opcode constants, ALU class codes, datapath select values and the
// per-state control-word decode.
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      EXEC_R   = 4'd6,
      R_WB     = 4'd7,
      EXEC_I   = 4'd8,
      I_WB     = 4'd9,
      BRANCH   = 4'd10,
      JUMP     = 4'd11,
      TRAP     = 4'd12
   } state_t;

   // Instruction opcodes (instruction bits [31:26])
   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_SLTI = 6'h0A;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_SUBI = 6'h0E;
   localparam logic [5:0] OP_LUI  = 6'h0F;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   // ALU-control class codes
   localparam logic [2:0] ALU_R    = 3'b000;
   localparam logic [2:0] ALU_BR   = 3'b001;
   localparam logic [2:0] ALU_MEM  = 3'b010;
   localparam logic [2:0] ALU_ADDI = 3'b011;
   localparam logic [2:0] ALU_ANDI = 3'b100;
   localparam logic [2:0] ALU_ORI  = 3'b101;
   localparam logic [2:0] ALU_SUBI = 3'b110;
   localparam logic [2:0] ALU_SLTI = 3'b111;

   // ALU B-operand select
   localparam logic [1:0] SRCB_REG   = 2'd0;
   localparam logic [1:0] SRCB_FOUR  = 2'd1;
   localparam logic [1:0] SRCB_SEXT  = 2'd2;
   localparam logic [1:0] SRCB_UPPER = 2'd3;

   // PC source select
   localparam logic [1:0] PC_ALU    = 2'd0;
   localparam logic [1:0] PC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [2:0] alu_op;
   } ctrl_t;

   // States that dwell for a memory access
   function automatic logic is_wait_state(state_t s);
      return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
   endfunction

   // ALU class for the immediate-format instructions; LUI shares the add class
   function automatic logic [2:0] imm_alu_op(logic [5:0] op);
      case (op)
         OP_ADDI: return ALU_ADDI;
         OP_ANDI: return ALU_ANDI;
         OP_ORI:  return ALU_ORI;
         OP_SUBI: return ALU_SUBI;
         OP_SLTI: return ALU_SLTI;
         default: return ALU_MEM;
      endcase
   endfunction

   // Control word for a state. 'last' marks the final cycle of a memory dwell.
   // States that compute from a register operand (address, immediate op,
   // branch compare) select register A on the ALU's A input.
   function automatic ctrl_t ctrl_for(state_t s, logic last, logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.mem_read  = 1'b1;
            c.ir_write  = last;
            c.pc_write  = last;
            c.alu_src_b = SRCB_FOUR;
            c.alu_op    = ALU_MEM;
            c.pc_source = PC_ALU;
         end
         DECODE: begin
            c.alu_src_b = SRCB_SEXT;
            c.alu_op    = ALU_MEM;
         end
         MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_SEXT;
            c.alu_op    = ALU_MEM;
         end
         MEM_RD:  c.mem_read  = 1'b1;
         MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         MEM_WR:  c.mem_write = 1'b1;
         EXEC_R: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_REG;
            c.alu_op    = ALU_R;
         end
         R_WB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         EXEC_I: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = (op == OP_LUI) ? SRCB_UPPER : SRCB_SEXT;
            c.alu_op    = imm_alu_op(op);
         end
         I_WB:    c.reg_write = 1'b1;
         BRANCH: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = ALU_BR;
            c.pc_source = PC_ALUOUT;
         end
         JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = PC_JUMP;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Memory-access dwell counter: loads MEM_WAIT, counts down to zero and
// flags the last cycle of the dwell with 'done'.
module mem_wait_ctr #(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       dec,
   output logic [3:0] count,
   output logic       done
);

   localparam logic [3:0] INIT = 4'(MEM_WAIT);

   // Reload on reset or state entry, otherwise count down and hold at zero
   always_ff @(posedge clk) begin
      if (rst || load)
         count <= INIT;
      else if (dec && (count != 4'd0))
         count <= count - 4'd1;
   end

   assign done = (count == 4'd0);

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-like datapath.
// Optional build macro MC_ILLEGAL_TRAP_EN: illegal opcodes park the FSM in
// TRAP with the 'trap' output high until reset; without it they act as NOPs.
module multicycle_control
   import mc_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   output logic       pc_write,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic [2:0] alu_op,
`ifdef MC_ILLEGAL_TRAP_EN
   output logic       trap,
`endif
   output logic [3:0] state
);

   localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

`ifdef MC_ILLEGAL_TRAP_EN
   localparam state_t ILLEGAL_NEXT = TRAP;
   localparam state_t TRAP_NEXT    = TRAP;
`else
   localparam state_t ILLEGAL_NEXT = FETCH;
   localparam state_t TRAP_NEXT    = FETCH;
`endif

   state_t     cur;
   state_t     nxt;
   ctrl_t      ctrl_q;
   ctrl_t      ctrl_d;
   logic       started;
   logic       stay;
   logic       next_last;
   logic       branch_taken;
   logic       ctr_done;
   logic [3:0] ctr_count;

   mem_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait (
      .clk   (clk),
      .rst   (rst),
      .load  (!stay),
      .dec   (stay),
      .count (ctr_count),
      .done  (ctr_done)
   );

   // Next-state selection; the first cycle out of reset opens a fresh fetch
   always_comb begin
      // NOTE: default assignment first so every path drives nxt and no latch is inferred.
      nxt = cur;
      if (!started) begin
         nxt = FETCH;
      end else begin
         case (cur)
            FETCH:    if (ctr_done) nxt = DECODE;
            DECODE: begin
               case (opcode)
                  OP_LW, OP_SW:  nxt = MEM_ADDR;
                  OP_R:          nxt = EXEC_R;
                  OP_ADDI, OP_ANDI, OP_ORI,
                  OP_SUBI, OP_SLTI, OP_LUI:
                                 nxt = EXEC_I;
                  OP_BEQ, OP_BNE: nxt = BRANCH;
                  OP_J:          nxt = JUMP;
                  default:       nxt = ILLEGAL_NEXT;
               endcase
            end
            MEM_ADDR: nxt = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   if (ctr_done) nxt = MEM_WB;
            MEM_WR:   if (ctr_done) nxt = FETCH;
            MEM_WB, R_WB, I_WB, BRANCH, JUMP:
                      nxt = FETCH;
            EXEC_R:   nxt = R_WB;
            EXEC_I:   nxt = I_WB;
            TRAP:     nxt = TRAP_NEXT;
            default:  nxt = FETCH;
         endcase
      end
   end

   // A dwell continues only while staying in a wait state; any other
   // transition reloads the counter so the next dwell starts from MEM_WAIT.
   assign stay      = started && (nxt == cur) && is_wait_state(cur);
   assign next_last = stay ? (ctr_count == 4'd1) : (WAIT_INIT == 4'd0);
   assign ctrl_d    = ctrl_for(nxt, next_last, opcode);

   // State and registered control word for the state being entered
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      if (rst) begin
         cur     <= FETCH;
         started <= 1'b0;
         ctrl_q  <= '0;
      end else begin
         cur     <= nxt;
         started <= 1'b1;
         ctrl_q  <= ctrl_d;
      end
   end

   // The branch decision is the only output that follows the live zero flag
   assign branch_taken = (cur == BRANCH) &&
                         (((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero));

   assign pc_write   = ctrl_q.pc_write | branch_taken;
   assign ir_write   = ctrl_q.ir_write;
   assign mem_read   = ctrl_q.mem_read;
   assign mem_write  = ctrl_q.mem_write;
   assign reg_write  = ctrl_q.reg_write;
   assign reg_dst    = ctrl_q.reg_dst;
   assign mem_to_reg = ctrl_q.mem_to_reg;
   assign alu_src_a  = ctrl_q.alu_src_a;
   assign alu_src_b  = ctrl_q.alu_src_b;
   assign pc_source  = ctrl_q.pc_source;
   assign alu_op     = ctrl_q.alu_op;
   assign state      = cur;

`ifdef MC_ILLEGAL_TRAP_EN
   assign trap = (cur == TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected control
// words are queued per instruction and compared as the FSM steps.
// dut0 runs with MEM_WAIT=0, dut3 with MEM_WAIT=3.
module tb_multicycle_control;
   import mc_pkg::*;

   typedef struct packed {
      logic [3:0] st;
      logic       trap;
      logic       pc_write;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [2:0] alu_op;
   } obs_t;

   typedef struct packed {
      obs_t       o;
      logic [5:0] op;
      logic       z;
   } exp_t;

   localparam obs_t E_IDLE       = '{st: FETCH, default: '0};
   localparam obs_t E_FETCH_WAIT = '{st: FETCH, mem_read: 1'b1, alu_src_b: 2'd1, alu_op: 3'b010, default: '0};
   localparam obs_t E_FETCH_LAST = '{st: FETCH, pc_write: 1'b1, ir_write: 1'b1, mem_read: 1'b1,
                                     alu_src_b: 2'd1, alu_op: 3'b010, default: '0};
   localparam obs_t E_DECODE     = '{st: DECODE, alu_src_b: 2'd2, alu_op: 3'b010, default: '0};
   localparam obs_t E_MEM_ADDR   = '{st: MEM_ADDR, alu_src_a: 1'b1, alu_src_b: 2'd2, alu_op: 3'b010, default: '0};
   localparam obs_t E_MEM_RD     = '{st: MEM_RD, mem_read: 1'b1, default: '0};
   localparam obs_t E_MEM_WB     = '{st: MEM_WB, reg_write: 1'b1, mem_to_reg: 1'b1, default: '0};
   localparam obs_t E_MEM_WR     = '{st: MEM_WR, mem_write: 1'b1, default: '0};
   localparam obs_t E_EXEC_R     = '{st: EXEC_R, alu_src_a: 1'b1, default: '0};
   localparam obs_t E_R_WB       = '{st: R_WB, reg_write: 1'b1, reg_dst: 1'b1, default: '0};
   localparam obs_t E_I_WB       = '{st: I_WB, reg_write: 1'b1, default: '0};
   localparam obs_t E_JUMP       = '{st: JUMP, pc_write: 1'b1, pc_source: 2'd2, default: '0};
   localparam obs_t E_TRAP       = '{st: TRAP, trap: 1'b1, default: '0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // dut0 signals
   logic       rst0, zero0;
   logic [5:0] opcode0;
   logic       pc_write0, ir_write0, mem_read0, mem_write0, reg_write0, reg_dst0, mem_to_reg0, alu_src_a0;
   logic [1:0] alu_src_b0, pc_source0;
   logic [2:0] alu_op0;
   logic [3:0] state0;
   // dut3 signals
   logic       rst3, zero3;
   logic [5:0] opcode3;
   logic       pc_write3, ir_write3, mem_read3, mem_write3, reg_write3, reg_dst3, mem_to_reg3, alu_src_a3;
   logic [1:0] alu_src_b3, pc_source3;
   logic [2:0] alu_op3;
   logic [3:0] state3;
`ifdef MC_ILLEGAL_TRAP_EN
   logic       trap0, trap3;
`endif

   multicycle_control #(.MEM_WAIT(0)) dut0 (
      .clk(clk), .rst(rst0), .opcode(opcode0), .zero(zero0),
      .pc_write(pc_write0), .ir_write(ir_write0), .mem_read(mem_read0), .mem_write(mem_write0),
      .reg_write(reg_write0), .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0), .alu_src_a(alu_src_a0),
      .alu_src_b(alu_src_b0), .pc_source(pc_source0), .alu_op(alu_op0),
`ifdef MC_ILLEGAL_TRAP_EN
      .trap(trap0),
`endif
      .state(state0)
   );

   multicycle_control #(.MEM_WAIT(3)) dut3 (
      .clk(clk), .rst(rst3), .opcode(opcode3), .zero(zero3),
      .pc_write(pc_write3), .ir_write(ir_write3), .mem_read(mem_read3), .mem_write(mem_write3),
      .reg_write(reg_write3), .reg_dst(reg_dst3), .mem_to_reg(mem_to_reg3), .alu_src_a(alu_src_a3),
      .alu_src_b(alu_src_b3), .pc_source(pc_source3), .alu_op(alu_op3),
`ifdef MC_ILLEGAL_TRAP_EN
      .trap(trap3),
`endif
      .state(state3)
   );

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t q[$];

   function automatic obs_t sample0();
      obs_t o;
      o.st = state0; o.pc_write = pc_write0; o.ir_write = ir_write0; o.mem_read = mem_read0;
      o.mem_write = mem_write0; o.reg_write = reg_write0; o.reg_dst = reg_dst0;
      o.mem_to_reg = mem_to_reg0; o.alu_src_a = alu_src_a0; o.alu_src_b = alu_src_b0;
      o.pc_source = pc_source0; o.alu_op = alu_op0;
`ifdef MC_ILLEGAL_TRAP_EN
      o.trap = trap0;
`else
      o.trap = 1'b0;
`endif
      return o;
   endfunction

   function automatic obs_t sample3();
      obs_t o;
      o.st = state3; o.pc_write = pc_write3; o.ir_write = ir_write3; o.mem_read = mem_read3;
      o.mem_write = mem_write3; o.reg_write = reg_write3; o.reg_dst = reg_dst3;
      o.mem_to_reg = mem_to_reg3; o.alu_src_a = alu_src_a3; o.alu_src_b = alu_src_b3;
      o.pc_source = pc_source3; o.alu_op = alu_op3;
`ifdef MC_ILLEGAL_TRAP_EN
      o.trap = trap3;
`else
      o.trap = 1'b0;
`endif
      return o;
   endfunction

   function automatic void add(input obs_t o, input logic [5:0] op, input logic z);
      exp_t e;
      e.o = o; e.op = op; e.z = z;
      q.push_back(e);
   endfunction

   function automatic obs_t exec_i(input logic [2:0] aop, input logic [1:0] asb);
      obs_t r;
      r = '0; r.st = EXEC_I; r.alu_src_a = 1'b1; r.alu_src_b = asb; r.alu_op = aop;
      return r;
   endfunction

   function automatic obs_t branch_o(input logic pw);
      obs_t r;
      r = '0; r.st = BRANCH; r.pc_write = pw; r.alu_src_a = 1'b1; r.pc_source = 2'd1; r.alu_op = 3'b001;
      return r;
   endfunction

   // Queue the expected per-cycle outputs of one instruction; w = MEM_WAIT
   function automatic void push_instr(input logic [5:0] op, input logic z, input int w);
      for (int i = 0; i < w; i++) add(E_FETCH_WAIT, op, z);
      add(E_FETCH_LAST, op, z);
      add(E_DECODE, op, z);
      case (op)
         OP_LW: begin
            add(E_MEM_ADDR, op, z);
            for (int i = 0; i <= w; i++) add(E_MEM_RD, op, z);
            add(E_MEM_WB, op, z);
         end
         OP_SW: begin
            add(E_MEM_ADDR, op, z);
            for (int i = 0; i <= w; i++) add(E_MEM_WR, op, z);
         end
         OP_R:    begin add(E_EXEC_R, op, z); add(E_R_WB, op, z); end
         OP_ADDI: begin add(exec_i(3'b011, 2'd2), op, z); add(E_I_WB, op, z); end
         OP_ANDI: begin add(exec_i(3'b100, 2'd2), op, z); add(E_I_WB, op, z); end
         OP_ORI:  begin add(exec_i(3'b101, 2'd2), op, z); add(E_I_WB, op, z); end
         OP_SUBI: begin add(exec_i(3'b110, 2'd2), op, z); add(E_I_WB, op, z); end
         OP_SLTI: begin add(exec_i(3'b111, 2'd2), op, z); add(E_I_WB, op, z); end
         OP_LUI:  begin add(exec_i(3'b010, 2'd3), op, z); add(E_I_WB, op, z); end
         OP_BEQ:  add(branch_o(z), op, z);
         OP_BNE:  add(branch_o(!z), op, z);
         OP_J:    add(E_JUMP, op, z);
         default: ;
      endcase
   endfunction

   task automatic test_reset();
      obs_t o;
      rst0 = 1'b1; rst3 = 1'b1; opcode0 = OP_J; opcode3 = OP_LW; zero0 = 1'b1; zero3 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         o = sample0(); n_checks++;
         if (o !== E_IDLE) $display("FAIL reset dut0 cycle %0d: got %h, expected %h", i, o, E_IDLE);
         else n_pass++;
         o = sample3(); n_checks++;
         if (o !== E_IDLE) $display("FAIL reset dut3 cycle %0d: got %h, expected %h", i, o, E_IDLE);
         else n_pass++;
      end
      rst0 = 1'b0;
   endtask

   task automatic test_lw();
      exp_t e; obs_t o; int c = 0;
      push_instr(OP_LW, 1'b0, 0);
      while (q.size() > 0) begin
         e = q.pop_front();
         @(posedge clk); #1; opcode0 = e.op; zero0 = e.z;
         @(negedge clk); o = sample0(); n_checks++; c++;
         if (o !== e.o) $display("FAIL lw cycle %0d: got %h, expected %h", c, o, e.o);
         else n_pass++;
      end
   endtask

   task automatic test_branch();
      exp_t e; obs_t o; int c = 0;
      push_instr(OP_BEQ, 1'b1, 0);
      push_instr(OP_BEQ, 1'b0, 0);
      push_instr(OP_BNE, 1'b1, 0);
      push_instr(OP_BNE, 1'b0, 0);
      while (q.size() > 0) begin
         e = q.pop_front();
         @(posedge clk); #1; opcode0 = e.op; zero0 = e.z;
         @(negedge clk); o = sample0(); n_checks++; c++;
         if (o !== e.o) $display("FAIL branch cycle %0d op %h zero %b: got %h, expected %h", c, e.op, e.z, o, e.o);
         else n_pass++;
      end
   endtask

   task automatic test_itype();
      exp_t e; obs_t o; int c = 0;
      logic [5:0] ops [9] = '{OP_ANDI, OP_LUI, OP_SLTI, OP_ADDI, OP_ORI, OP_SUBI, OP_R, OP_SW, OP_J};
      foreach (ops[i]) push_instr(ops[i], 1'b0, 0);
      while (q.size() > 0) begin
         e = q.pop_front();
         @(posedge clk); #1; opcode0 = e.op; zero0 = e.z;
         @(negedge clk); o = sample0(); n_checks++; c++;
         if (o !== e.o) $display("FAIL itype cycle %0d op %h: got %h, expected %h", c, e.op, o, e.o);
         else n_pass++;
      end
   endtask

   task automatic test_illegal();
      exp_t e; obs_t o; int c = 0;
      push_instr(6'h3F, 1'b0, 0);
`ifdef MC_ILLEGAL_TRAP_EN
      for (int i = 0; i < 10; i++) add(E_TRAP, 6'h3F, 1'b0);
`else
      push_instr(OP_LW, 1'b0, 0);
`endif
      while (q.size() > 0) begin
         e = q.pop_front();
         @(posedge clk); #1; opcode0 = e.op; zero0 = e.z;
         @(negedge clk); o = sample0(); n_checks++; c++;
         if (o !== e.o) $display("FAIL illegal cycle %0d: got %h, expected %h", c, o, e.o);
         else n_pass++;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      rst0 = 1'b1;
      @(negedge clk); o = sample0(); n_checks++;
      if (o !== E_IDLE) $display("FAIL trap reset: got %h, expected %h", o, E_IDLE);
      else n_pass++;
      rst0 = 1'b0;
      push_instr(OP_R, 1'b0, 0);
      while (q.size() > 0) begin
         e = q.pop_front();
         @(posedge clk); #1; opcode0 = e.op; zero0 = e.z;
         @(negedge clk); o = sample0(); n_checks++; c++;
         if (o !== e.o) $display("FAIL after trap cycle %0d: got %h, expected %h", c, o, e.o);
         else n_pass++;
      end
`endif
   endtask

   task automatic test_back_to_back();
      exp_t e; obs_t o; int c = 0;
      logic [5:0] ops [12] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI,
                               OP_SLTI, OP_ANDI, OP_ORI, OP_SUBI, OP_LUI, OP_J};
      for (int i = 0; i < 16; i++)
         push_instr(ops[$urandom_range(0, 11)], 1'($urandom_range(0, 1)), 0);
      while (q.size() > 0) begin
         e = q.pop_front();
         @(posedge clk); #1; opcode0 = e.op; zero0 = e.z;
         @(negedge clk); o = sample0(); n_checks++; c++;
         if (o !== e.o) $display("FAIL b2b cycle %0d op %h zero %b: got %h, expected %h", c, e.op, e.z, o, e.o);
         else n_pass++;
      end
   endtask

   task automatic test_mem_wait();
      exp_t e; obs_t o; int c = 0;
      @(negedge clk); rst3 = 1'b0;
      push_instr(OP_SW, 1'b0, 3);
      push_instr(OP_LW, 1'b0, 3);
      while (q.size() > 0) begin
         e = q.pop_front();
         @(posedge clk); #1; opcode3 = e.op; zero3 = e.z;
         @(negedge clk); o = sample3(); n_checks++; c++;
         if (o !== e.o) $display("FAIL mem_wait cycle %0d: got %h, expected %h", c, o, e.o);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      exp_t e; obs_t o; int c = 0;
      // LW on dut3, interrupted in the second cycle of its MEM_RD dwell
      push_instr(OP_LW, 1'b0, 3);
      while (q.size() > 3) begin
         e = q.pop_front();
         @(posedge clk); #1; opcode3 = e.op; zero3 = e.z;
         @(negedge clk); o = sample3(); n_checks++; c++;
         if (o !== e.o) $display("FAIL reset_mid pre cycle %0d: got %h, expected %h", c, o, e.o);
         else n_pass++;
      end
      q.delete();
      rst3 = 1'b1;
      @(negedge clk); o = sample3(); n_checks++;
      if (o !== E_IDLE) $display("FAIL reset_mid in MEM_RD: got %h, expected %h", o, E_IDLE);
      else n_pass++;
      rst3 = 1'b0;
      // A full four-cycle fetch proves the dwell counter was reloaded
      push_instr(OP_R, 1'b0, 3);
      while (q.size() > 0) begin
         e = q.pop_front();
         @(posedge clk); #1; opcode3 = e.op; zero3 = e.z;
         @(negedge clk); o = sample3(); n_checks++; c++;
         if (o !== e.o) $display("FAIL reset_mid post cycle %0d: got %h, expected %h", c, o, e.o);
         else n_pass++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_lw();
      test_branch();
      test_itype();
      test_illegal();
      test_back_to_back();
      test_mem_wait();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0: extra wait cycles added to every memory access (0..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port opcode, input, 6, instruction bits [31:26] from the instruction register.
REQ-005 SHALL have port zero, input, 1, ALU zero flag.
REQ-006 SHALL have ports pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, all outputs, 1 bit each, as datapath strobes and selects.
REQ-007 SHALL have ports alu_src_b (output, 2: 0=regB, 1=const 4, 2=sign-ext imm, 3=imm<<16) and pc_source (output, 2: 0=ALU, 1=ALUOut, 2=jump target).
REQ-008 SHALL have port alu_op, output, 3, ALU-control class code.
REQ-009 SHALL have port state, output, 4, current FSM state for debug.

Function
REQ-010 SHALL be a Moore FSM; all outputs SHALL be decoded from registered state, except pc_write in BRANCH, which also depends on zero.
REQ-011 SHALL use these states: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, TRAP.
REQ-012 SHALL encode alu_op as 000 R-type, 001 BEQ/BNE, 010 LW/SW/LUI, 011 ADDI, 100 ANDI, 101 ORI, 110 SUBI, 111 SLTI.
REQ-013 SHALL decode opcodes R=0x00, LW=0x23, SW=0x2B, BEQ=0x04, BNE=0x05, ADDI=0x08, SLTI=0x0A, ANDI=0x0C, ORI=0x0D, SUBI=0x0E, LUI=0x0F, J=0x02.
REQ-014 FETCH SHALL assert mem_read, ir_write, pc_write with alu_src_a=0, alu_src_b=1, alu_op=010, pc_source=0; ir_write and pc_write SHALL assert only in the last wait cycle.
REQ-015 DECODE SHALL precompute the branch target (alu_src_a=0, alu_src_b=2, alu_op=010) and SHALL branch on opcode: LW/SW to MEM_ADDR; R to EXEC_R; ADDI/ANDI/ORI/SUBI/SLTI/LUI to EXEC_I; BEQ/BNE to BRANCH; J to JUMP; other to illegal handling (REQ-024).
REQ-016 MEM_ADDR SHALL go to MEM_RD for LW and to MEM_WR for SW; MEM_RD SHALL go to MEM_WB, and MEM_WB (reg_write=1, mem_to_reg=1, reg_dst=0) SHALL go to FETCH.
REQ-017 EXEC_I SHALL use alu_src_b=3 for LUI and 2 otherwise, with alu_op per REQ-012; I_WB SHALL assert reg_write with reg_dst=0.
REQ-018 EXEC_R SHALL use alu_src_a=1, alu_src_b=0, alu_op=000; R_WB SHALL assert reg_write with reg_dst=1.
REQ-019 BRANCH SHALL use alu_op=001 and pc_source=1, and SHALL assert pc_write iff (BEQ and zero) or (BNE and not zero).
REQ-020 JUMP SHALL assert pc_write with pc_source=2.
REQ-021 MEM_WR, R_WB, I_WB, BRANCH and JUMP SHALL return to FETCH.
REQ-022 FETCH, MEM_RD and MEM_WR SHALL each last MEM_WAIT+1 cycles, counted by a 4-bit down-counter loaded on entry; mem_read/mem_write SHALL be held for the whole dwell.
REQ-023 Cycle counts with MEM_WAIT=0: LW 5; SW, R, I-type 4; BEQ/BNE/J 3.
REQ-024 Illegal opcode handling SHALL be per REQ-028/029.
REQ-025 Outputs not listed for a state SHALL be 0; strobes SHALL never assert in two consecutive states unless listed there.

Reset
REQ-026 rst SHALL force state=FETCH, the wait counter=MEM_WAIT and all strobes to 0 on the next edge, and SHALL take priority mid-instruction and mid-wait; the first fetch SHALL begin on the cycle after rst deasserts.
REQ-027 rst asserted in TRAP SHALL return the FSM to FETCH.

Configuration
REQ-028 With macro MC_ILLEGAL_TRAP_EN defined, an illegal opcode in DECODE SHALL go to TRAP, where all strobes are 0 and an extra 1-bit output trap is held at 1 until rst.
REQ-029 Without MC_ILLEGAL_TRAP_EN, the trap port SHALL be absent, TRAP unreachable, and an illegal opcode SHALL return DECODE to FETCH as a NOP.

Structure
REQ-030 State encodings, the opcode constants and the alu_op class codes SHALL live in shared package mc_pkg.
REQ-031 The wait counter SHALL be the sub-module mem_wait_ctr (load, decrement, done output); the FSM SHALL stay in the top module.

Verification
REQ-032 LW (0x23), MEM_WAIT=0 -> states FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB; reg_write=1 and mem_to_reg=1 only in cycle 5.
REQ-033 BEQ with zero=1, then zero=0 -> pc_write=1 in BRANCH, then 0; BNE -> the inverse.
REQ-034 ANDI 0x0C -> alu_op=100 in EXEC_I; LUI 0x0F -> alu_src_b=3, alu_op=010; SLTI -> alu_op=111.
REQ-035 MEM_WAIT=3, SW -> FETCH dwells 4 cycles with ir_write only in the 4th; MEM_WR holds mem_write 4 cycles.
REQ-036 opcode 0x3F -> FETCH next with the macro undefined; TRAP with trap=1 held 10 cycles with it defined; rst pulse in MEM_RD or TRAP -> FETCH with all strobes 0.
